top_fpga_hid: RTL and testbench
===============================

// Module: top_fpga_hid
// PURPOSE
//  FPGA top of the HID input path: receives 8N1 serial bytes on rx_pin, parses
//  3-byte packets (header, X, Y) and presents a drawing command plus 6-bit
//  screen coordinates to the screen/painter logic with a 1-cycle valid strobe.
//  Sits between the external UART link and the retro_paint display pipeline.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD_RATE  9600        serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (5208)
// PORTS
//  clk            in   1  system clock, 50 MHz; all logic on rising edge
//  reset_btn      in   1  synchronous, active-high reset
//  rx_pin         in   1  UART RX line, idle high, asynchronous to clk
//  cmd_to_screen  out  3  command of last complete packet (1=move, 2=draw, others passed through)
//  x_to_screen    out  6  X coordinate of last complete packet
//  y_to_screen    out  6  Y coordinate of last complete packet
//  valid_pulse    out  1  high exactly one clk when a new packet is presented
// BEHAVIOUR
//  Reset (reset_btn=1 at a clk edge): cmd/x/y=0, valid_pulse=0, UART RX to IDLE,
//   parser to WAIT_HDR, synchronizer flops preset to 1. Reset mid-byte/mid-packet
//   discards partial data.
//  UART RX: rx_pin through 2-FF synchronizer. IDLE: falling edge -> START.
//   START: at CLKS_PER_BIT/2 re-sample; 0 -> DATA, 1 -> IDLE (glitch).
//   DATA: sample every CLKS_PER_BIT, LSB first, 8 bits. STOP: sample after
//   CLKS_PER_BIT; 1 -> assert byte_valid 1 clk with byte; 0 -> framing error,
//   byte dropped. Return to IDLE; back-to-back bytes (no extra idle) supported.
//  Parser FSM (advances only on byte_valid):
//   WAIT_HDR: byte[7:6]==2'b11 -> latch cmd=byte[2:0] -> WAIT_X; else ignore.
//     byte[5:3] reserved, ignored.
//   WAIT_X: byte[7:6]==2'b11 -> treat as new header (resync, stay WAIT_X,
//     new cmd); else x_reg=byte[5:0] -> WAIT_Y.
//   WAIT_Y: byte[7:6]==2'b11 -> resync as header -> WAIT_X; else
//     y=byte[5:0], commit -> WAIT_HDR.
//  Commit: on the clk after the Y byte's byte_valid, cmd_to_screen/x/y update
//   together and valid_pulse=1 for exactly one clk; outputs then hold until the
//   next commit. Latency: 1 clk from Y byte_valid to valid_pulse.
//  Data bytes bits[7:6] other than 2'b11 are truncated (only [5:0] used).
//  No timeout: a stalled partial packet waits until completed or resynced.
// STRUCTURE
//  Package hid_pkg: CMD_MOVE=3'd1, CMD_DRAW=3'd2, HDR_MARK=2'b11,
//   parser state enum {WAIT_HDR,WAIT_X,WAIT_Y}, coord width COORD_W=6.
//  Sub-module uart_rx (CLK_FREQ,BAUD_RATE; clk,reset,rx -> data[7:0],valid);
//   parser FSM and output registers inline in top_fpga_hid.
// TESTING  (bit time 104166 ns, clk period 20 ns)
//  Hold reset_btn=1 several clks -> all outputs 0, valid_pulse never high.
//  Bytes C1,0A,05 -> one valid_pulse; cmd=1,x=10,y=5 held afterwards.
//  Then C2,0A,05 -> one valid_pulse; cmd=2,x=10,y=5.
//  C1,0A,C2,03,04 -> only one valid_pulse: cmd=2,x=3,y=4 (resync on header).
//  Byte with stop bit=0 or 1-clk low glitch on rx_pin -> no byte, no pulse.
//  Assert reset_btn after C1,0A -> then 05 alone produces no valid_pulse.

Source files
------------

// File: rtl/hid_pkg.sv
// Shared types and constants for the HID serial input path: packet markers,
// command codes, coordinate width and the UART/parser state encodings.
package hid_pkg;

    localparam logic [2:0] CMD_MOVE = 3'd1;
    localparam logic [2:0] CMD_DRAW = 3'd2;
    localparam logic [1:0] HDR_MARK = 2'b11;
    localparam int         COORD_W  = 6;

    typedef enum logic [1:0] {
        WAIT_HDR,
        WAIT_X,
        WAIT_Y
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic isHeader(input logic [7:0] b);
        return b[7:6] == HDR_MARK;
    endfunction

endpackage

// File: rtl/hid_if.sv
// Screen-side bundle: the command and coordinates of the last complete packet
// plus a one-cycle strobe marking a new packet.
interface hid_if;
    import hid_pkg::*;

    logic [2:0]         cmd_to_screen;
    logic [COORD_W-1:0] x_to_screen;
    logic [COORD_W-1:0] y_to_screen;
    logic               valid_pulse;

    modport master (
        output cmd_to_screen,
        output x_to_screen,
        output y_to_screen,
        output valid_pulse
    );

    modport slave (
        input cmd_to_screen,
        input x_to_screen,
        input y_to_screen,
        input valid_pulse
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, LSB first, and emits a
// one-cycle valid with the byte only when the stop bit is high.
module uart_rx
    import hid_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             rxPrev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] clkCnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;

    // Synchronizer and edge-detect flops reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            rxPrev_q <= 1'b1;
            state_q  <= RX_IDLE;
            clkCnt_q <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            rxPrev_q <= sync2_q;
            valid_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    clkCnt_q <= '0;
                    if (rxPrev_q && !sync2_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (clkCnt_q == HALF_LAST) begin
                        clkCnt_q <= '0;
                        bitIdx_q <= '0;
                        state_q  <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clkCnt_q == FULL_LAST) begin
                        clkCnt_q <= '0;
                        shift_q  <= {sync2_q, shift_q[7:1]};
                        if (bitIdx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clkCnt_q == FULL_LAST) begin
                        clkCnt_q <= '0;
                        state_q  <= RX_IDLE;
                        if (sync2_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/top_fpga_hid.sv
// FPGA top of the HID input path: UART bytes are parsed as header/X/Y packets
// and presented to the painter with a one-cycle valid strobe.
module top_fpga_hid
    import hid_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic  clk,
    input  logic  reset_btn,
    input  logic  rx_pin,
    hid_if.master scr
);

    logic [7:0]         rxByte;
    logic               rxValid;

    parse_state_t       state_q;
    logic [2:0]         cmdLatch_q;
    logic [COORD_W-1:0] xLatch_q;
    logic [2:0]         cmd_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               valid_q;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_uart_rx (
        .clk   (clk),
        .reset (reset_btn),
        .rx    (rx_pin),
        .data  (rxByte),
        .valid (rxValid)
    );

    // A header byte in any state restarts the packet, so a lost byte costs one packet at most.
    always_ff @(posedge clk) begin
        if (reset_btn) begin
            state_q    <= WAIT_HDR;
            cmdLatch_q <= '0;
            xLatch_q   <= '0;
            cmd_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (rxValid) begin
                if (isHeader(rxByte)) begin
                    cmdLatch_q <= rxByte[2:0];
                    state_q    <= WAIT_X;
                end else begin
                    case (state_q)
                        WAIT_X: begin
                            xLatch_q <= rxByte[COORD_W-1:0];
                            state_q  <= WAIT_Y;
                        end
                        WAIT_Y: begin
                            cmd_q   <= cmdLatch_q;
                            x_q     <= xLatch_q;
                            y_q     <= rxByte[COORD_W-1:0];
                            valid_q <= 1'b1;
                            state_q <= WAIT_HDR;
                        end
                        default: state_q <= WAIT_HDR;
                    endcase
                end
            end
        end
    end

    assign scr.cmd_to_screen = cmd_q;
    assign scr.x_to_screen   = x_q;
    assign scr.y_to_screen   = y_q;
    assign scr.valid_pulse   = valid_q;

endmodule

// File: tb/tb_top_fpga_hid.sv
// Scoreboard bench for top_fpga_hid: expected packets are queued as bytes are
// sent and popped by a monitor whenever valid_pulse fires.
module tb_top_fpga_hid;
    import hid_pkg::*;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 3_125_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;

    typedef struct packed {
        logic [2:0] cmd;
        logic [5:0] x;
        logic [5:0] y;
    } exp_t;

    logic clk;
    logic reset_btn;
    logic rx_pin;

    hid_if scrIf ();

    top_fpga_hid #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .reset_btn (reset_btn),
        .rx_pin    (rx_pin),
        .scr       (scrIf)
    );

    exp_t expQ[$];
    int   checks     = 0;
    int   failures   = 0;
    int   pulseCount = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Every strobe must match the oldest queued packet; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (scrIf.valid_pulse === 1'b1) begin
            exp_t e;
            exp_t got;
            pulseCount++;
            checks++;
            got = {scrIf.cmd_to_screen, scrIf.x_to_screen, scrIf.y_to_screen};
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse got cmd=%0d x=%0d y=%0d, no packet expected",
                         got.cmd, got.x, got.y);
            end else begin
                e = expQ.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("[TB] FAIL packet got cmd=%0d x=%0d y=%0d expected cmd=%0d x=%0d y=%0d",
                             got.cmd, got.x, got.y, e.cmd, e.x, e.y);
                end
            end
        end
    end

    function automatic exp_t mkExp(input logic [2:0] c, input logic [5:0] x, input logic [5:0] y);
        exp_t e;
        e.cmd = c;
        e.x   = x;
        e.y   = y;
        return e;
    endfunction

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx_pin = 1'b0;
        waitClks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            waitClks(CPB);
        end
        rx_pin = stopBit;
        waitClks(CPB);
        rx_pin = 1'b1;
    endtask

    task automatic test_reset;
        reset_btn = 1'b1;
        rx_pin    = 1'b1;
        waitClks(5);
        checks++;
        if (scrIf.cmd_to_screen !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_cmd got %0d expected 0", scrIf.cmd_to_screen);
        end
        checks++;
        if (scrIf.x_to_screen !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_x got %0d expected 0", scrIf.x_to_screen);
        end
        checks++;
        if (scrIf.y_to_screen !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_y got %0d expected 0", scrIf.y_to_screen);
        end
        checks++;
        if (scrIf.valid_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid got %0b expected 0", scrIf.valid_pulse);
        end
        reset_btn = 1'b0;
        waitClks(5);
        checks++;
        if (pulseCount !== 0) begin
            failures++;
            $display("[TB] FAIL reset_no_pulse got %0d pulses expected 0", pulseCount);
        end
    endtask

    task automatic checkPacketResult(input string name, input int startCnt, input exp_t held);
        checks++;
        if (pulseCount - startCnt !== 1) begin
            failures++;
            $display("[TB] FAIL %s_pulse_count got %0d expected 1", name, pulseCount - startCnt);
        end
        checks++;
        if (expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL %s_queue got %0d pending expected 0", name, expQ.size());
            expQ.delete();
        end
        checks++;
        if ({scrIf.cmd_to_screen, scrIf.x_to_screen, scrIf.y_to_screen} !== held) begin
            failures++;
            $display("[TB] FAIL %s_hold got cmd=%0d x=%0d y=%0d expected cmd=%0d x=%0d y=%0d", name,
                     scrIf.cmd_to_screen, scrIf.x_to_screen, scrIf.y_to_screen, held.cmd, held.x, held.y);
        end
    endtask

    task automatic test_move_packet;
        int startCnt = pulseCount;
        exp_t e = mkExp(CMD_MOVE, 6'd10, 6'd5);
        expQ.push_back(e);
        sendByte(8'hC1, 1'b1);
        sendByte(8'h0A, 1'b1);
        sendByte(8'h05, 1'b1);
        waitClks(3 * CPB);
        checkPacketResult("move", startCnt, e);
    endtask

    task automatic test_draw_packet;
        int startCnt = pulseCount;
        exp_t e = mkExp(CMD_DRAW, 6'd10, 6'd5);
        expQ.push_back(e);
        sendByte(8'hC2, 1'b1);
        sendByte(8'h0A, 1'b1);
        sendByte(8'h05, 1'b1);
        waitClks(3 * CPB);
        checkPacketResult("draw", startCnt, e);
    endtask

    task automatic test_resync;
        int startCnt = pulseCount;
        exp_t e = mkExp(CMD_DRAW, 6'd3, 6'd4);
        expQ.push_back(e);
        sendByte(8'hC1, 1'b1);
        sendByte(8'h0A, 1'b1);
        sendByte(8'hC2, 1'b1);
        sendByte(8'h03, 1'b1);
        sendByte(8'h04, 1'b1);
        waitClks(3 * CPB);
        checkPacketResult("resync", startCnt, e);
    endtask

    task automatic test_framing_error;
        int startCnt = pulseCount;
        exp_t e = mkExp(CMD_MOVE, 6'd10, 6'd7);
        sendByte(8'hC1, 1'b1);
        sendByte(8'h0A, 1'b1);
        sendByte(8'h05, 1'b0);
        waitClks(3 * CPB);
        checks++;
        if (pulseCount !== startCnt) begin
            failures++;
            $display("[TB] FAIL framing_dropped got %0d pulses expected 0", pulseCount - startCnt);
        end
        expQ.push_back(e);
        sendByte(8'h47, 1'b1);
        waitClks(3 * CPB);
        checkPacketResult("framing", startCnt, e);
    endtask

    task automatic test_glitch;
        int startCnt = pulseCount;
        exp_t e = mkExp(CMD_DRAW, 6'd1, 6'd2);
        rx_pin = 1'b0;
        waitClks(1);
        rx_pin = 1'b1;
        waitClks(12 * CPB);
        sendByte(8'h0A, 1'b1);
        sendByte(8'h05, 1'b1);
        waitClks(3 * CPB);
        checks++;
        if (pulseCount !== startCnt) begin
            failures++;
            $display("[TB] FAIL glitch_no_pulse got %0d pulses expected 0", pulseCount - startCnt);
        end
        expQ.push_back(e);
        sendByte(8'hC2, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h02, 1'b1);
        waitClks(3 * CPB);
        checkPacketResult("glitch", startCnt, e);
    endtask

    task automatic test_reset_mid_packet;
        int startCnt = pulseCount;
        sendByte(8'hC1, 1'b1);
        sendByte(8'h0A, 1'b1);
        reset_btn = 1'b1;
        waitClks(3);
        reset_btn = 1'b0;
        waitClks(2);
        checks++;
        if ({scrIf.cmd_to_screen, scrIf.x_to_screen, scrIf.y_to_screen} !== 15'd0) begin
            failures++;
            $display("[TB] FAIL midreset_clear got cmd=%0d x=%0d y=%0d expected all 0",
                     scrIf.cmd_to_screen, scrIf.x_to_screen, scrIf.y_to_screen);
        end
        sendByte(8'h05, 1'b1);
        waitClks(3 * CPB);
        checks++;
        if (pulseCount !== startCnt) begin
            failures++;
            $display("[TB] FAIL midreset_no_pulse got %0d pulses expected 0", pulseCount - startCnt);
        end
        checks++;
        if ({scrIf.cmd_to_screen, scrIf.x_to_screen, scrIf.y_to_screen} !== 15'd0) begin
            failures++;
            $display("[TB] FAIL midreset_hold got cmd=%0d x=%0d y=%0d expected all 0",
                     scrIf.cmd_to_screen, scrIf.x_to_screen, scrIf.y_to_screen);
        end
    endtask

    initial begin
        reset_btn = 1'b1;
        rx_pin    = 1'b1;
        test_reset();
        test_move_packet();
        test_draw_packet();
        test_resync();
        test_framing_error();
        test_glitch();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
